// File: rtl/decode_ctrl_stage.sv
// ---------------------------------------------------------------------------
// decode_ctrl_stage
//
// Purpose: RV32 decode/control stage. Accepts a raw instruction through a
// valid/ready handshake, decodes it into a registered control bundle and
// presents that bundle downstream with a valid/ready handshake. Multiply and
// divide instructions stall the stage for a fixed number of cycles before
// the bundle is presented.
//
// Optional feature: define RV32M_EN to compile in multiply/divide support.
// Without it, funct7=0000001 R-type encodings decode as illegal and the
// stall path is never entered.
//
// Parameters:
//   MUL_CYCLES  stall cycles for MUL/MULH/MULHSU/MULHU (1..31)
//   DIV_CYCLES  stall cycles for DIV/DIVU/REM/REMU     (1..31)
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake, instr is the offered word
//   flush                 discard held or in-flight instruction
//   out_valid/out_ready   downstream handshake for the control bundle
//   reg_write .. illegal  registered control bundle fields
//   busy                  multiply/divide stall in progress
// ---------------------------------------------------------------------------
module decode_ctrl_stage #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        reg_write,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src,
    output logic [2:0]  imm_src,
    output logic        branch,
    output logic        jump,
    output logic [1:0]  dest_src,
    output logic [2:0]  mem_ctrl,
    output logic        mem_write,
    output logic        mdu_op,
    output logic        illegal,
    output logic        busy
);

`ifdef RV32M_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    localparam logic [4:0] MUL_CNT = 5'(MUL_CYCLES);
    localparam logic [4:0] DIV_CNT = 5'(DIV_CYCLES);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        MDU_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic       reg_write;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic [2:0] imm_src;
        logic       branch;
        logic       jump;
        logic [1:0] dest_src;
        logic [2:0] mem_ctrl;
        logic       mem_write;
        logic       mdu_op;
        logic       illegal;
    } ctrl_t;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    ctrl_t      bundle_q, bundle_d;
    ctrl_t      dec;
    logic       accept;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register specifiers and immediate bits are consumed by later stages.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default on entry so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        dec          = '0;
        dec.mem_ctrl = funct3;
        unique case (opcode)
            OP_REG: begin
                if (funct7 == F7_MULDIV && !MDU_EN) begin
                    dec         = '0;
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.alu_ctrl  = {instr[30], funct3};
                    dec.mdu_op    = (funct7 == F7_MULDIV);
                end
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                // Only the shift-right group carries an arithmetic flag in bit 30.
                dec.alu_ctrl  = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
            end
            OP_LOAD: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.dest_src  = 2'd1;
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.imm_src  = 3'd1;
                dec.alu_ctrl = {1'b0, funct3};
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'd2;
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'd3;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'd4;
                dec.dest_src  = 2'd3;
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'd0;
                dec.dest_src  = 2'd3;
            end
            default: begin
                dec         = '0;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and stall control
    // ------------------------------------------------------------------
    // Flush blocks acceptance so the word offered alongside it is dropped.
    assign in_ready = !flush &&
                      ((state_q == IDLE) || (state_q == HOLD && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bundle_d = accept ? dec : bundle_q;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        if (dec.mdu_op) begin
                            state_d = MDU_WAIT;
                            cnt_d   = funct3[2] ? DIV_CNT : MUL_CNT;
                        end else begin
                            state_d = HOLD;
                            cnt_d   = '0;
                        end
                    end else if (state_q == HOLD && out_ready) begin
                        state_d = IDLE;
                    end
                end
                MDU_WAIT: begin
                    // Leaving on count 1 lands HOLD in the same cycle the
                    // counter reads 0, so busy covers exactly N cycles.
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bundle_q <= bundle_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = (state_q == HOLD);
    assign busy      = MDU_EN && (state_q == MDU_WAIT);

    assign reg_write = bundle_q.reg_write;
    assign alu_ctrl  = bundle_q.alu_ctrl;
    assign alu_src   = bundle_q.alu_src;
    assign imm_src   = bundle_q.imm_src;
    assign branch    = bundle_q.branch;
    assign jump      = bundle_q.jump;
    assign dest_src  = bundle_q.dest_src;
    assign mem_ctrl  = bundle_q.mem_ctrl;
    assign mem_write = bundle_q.mem_write;
    assign mdu_op    = MDU_EN && bundle_q.mdu_op;
    assign illegal   = bundle_q.illegal;

endmodule
